// File: rtl/adder_seq_ctrl_pkg.sv
// Shared types and defaults for the sliced sequential adder (adder_seq_ctrl).
// The optional subtract mode is enabled by defining ADDER_SEQ_SUB_EN at compile time.
package adder_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_SLICE = 16;

    function automatic int idx_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/adder_seq_slice.sv
// Combinational SLICE-bit carry-bypass adder. When every bit propagates,
// the carry-out is taken directly from cin instead of the ripple chain.
module adder_seq_slice #(
    parameter int SLICE = 16
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);

    logic [SLICE-1:0] prop;
    logic             c;

    assign prop = a ^ b;

    always_comb begin
        c   = cin;
        sum = '0;
        for (int i = 0; i < SLICE; i++) begin
            sum[i] = prop[i] ^ c;
            c      = (a[i] & b[i]) | (prop[i] & c);
        end
        cout = (&prop) ? cin : c;
    end

endmodule

// File: rtl/adder_seq_ctrl.sv
// Sequencer performing one WIDTH-bit add over WIDTH/SLICE cycles on a shared slice adder.
// Define ADDER_SEQ_SUB_EN to add the in_sub port (A - B via inverted B and carry-in of 1).
module adder_seq_ctrl
    import adder_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef ADDER_SEQ_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = idx_width(NSLICE);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             out_valid_q;
    logic             in_ready_q;
    logic             busy_q;

    logic [SLICE-1:0] sl_a;
    logic [SLICE-1:0] sl_b;
    logic [SLICE-1:0] sl_sum;
    logic             sl_cout;
    logic [WIDTH-1:0] b_in;
    logic             cin_in;

    assign sl_a = a_q[idx_q*SLICE +: SLICE];
    assign sl_b = b_q[idx_q*SLICE +: SLICE];

`ifdef ADDER_SEQ_SUB_EN
    assign b_in   = in_sub ? ~in_b : in_b;
    assign cin_in = in_sub | in_cin;
`else
    assign b_in   = in_b;
    assign cin_in = in_cin;
`endif

    adder_seq_slice #(.SLICE(SLICE)) u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_q),
        .sum  (sl_sum),
        .cout (sl_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= in_a;
                        b_q        <= b_in;
                        carry_q    <= cin_in;
                        idx_q      <= '0;
                        state_q    <= ST_RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    sum_q[idx_q*SLICE +: SLICE] <= sl_sum;
                    carry_q <= sl_cout;
                    if (idx_q == IDX_LAST) begin
                        idx_q       <= '0;
                        cout_q      <= sl_cout;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    // Result registers are untouched here, so they hold under backpressure.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    idx_q       <= '0;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed testbench for adder_seq_ctrl (WIDTH=64, SLICE=16); covers subtract mode when ADDER_SEQ_SUB_EN is defined.
module tb_adder_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_a = '0;
    logic [63:0] in_b = '0;
    logic        in_cin = 1'b0;
    logic        in_sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_sum;
    logic        out_cout;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adder_seq_ctrl #(.WIDTH(64), .SLICE(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef ADDER_SEQ_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called in IDLE; accepts one operation, checks latency, result, hold and release.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic cin, input logic sub, input logic [63:0] es,
                          input logic ec, input int hold);
        int   lat;
        logic rdy_bad;
        logic stable_bad;
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = ~a; in_b = ~b;
        lat = 0;
        rdy_bad = 1'b0;
        while (!out_valid && lat < 20) begin
            if (in_ready) rdy_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd4);
        check({tag, "_ready_run"}, {63'd0, rdy_bad}, 64'd0);
        check({tag, "_sum"}, out_sum, es);
        check({tag, "_cout"}, {63'd0, out_cout}, {63'd0, ec});
        check({tag, "_ready_done"}, {63'd0, in_ready}, 64'd0);
        check({tag, "_busy_done"}, {63'd0, busy}, 64'd1);
        stable_bad = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!out_valid || out_sum !== es || out_cout !== ec || in_ready) stable_bad = 1'b1;
        end
        if (hold > 0) check({tag, "_hold"}, {63'd0, stable_bad}, 64'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_ready_idle"}, {63'd0, in_ready}, 64'd1);
        check({tag, "_busy_idle"}, {63'd0, busy}, 64'd0);
    endtask

    logic [63:0] b2b_a   [3];
    logic [63:0] b2b_b   [3];
    logic        b2b_c   [3];
    logic [63:0] b2b_s   [3];
    logic        b2b_co  [3];
    int          acc_t   [3];

    initial begin
        int   bound;
        logic seen;

        b2b_a[0] = 64'd1;                  b2b_b[0] = 64'd2;                  b2b_c[0] = 1'b0;
        b2b_s[0] = 64'd3;                  b2b_co[0] = 1'b0;
        b2b_a[1] = 64'hDEAD_BEEF_0000_0001; b2b_b[1] = 64'h1111_1111_FFFF_FFFF; b2b_c[1] = 1'b0;
        b2b_s[1] = 64'hEFBE_D001_0000_0000; b2b_co[1] = 1'b0;
        b2b_a[2] = 64'hFFFF_FFFF_FFFF_FFFF; b2b_b[2] = 64'hFFFF_FFFF_FFFF_FFFF; b2b_c[2] = 1'b1;
        b2b_s[2] = 64'hFFFF_FFFF_FFFF_FFFF; b2b_co[2] = 1'b1;

        #12;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_sum", out_sum, 64'd0);
        check("rst_cout", {63'd0, out_cout}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 10);
        run_op("cin", 64'h0000_1234_0000_FFFF, 64'd1, 1'b1, 1'b0, 64'h0000_1234_0001_0001, 1'b0, 2);
        run_op("bypass", 64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF, 1'b1, 1'b0, 64'd0, 1'b1, 0);
        run_op("topcarry", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 64'd1, 1'b1, 0);

        // Abort during RUN with idx==2.
        in_a = 64'h1234_5678_9ABC_DEF0; in_b = 64'h0FED_CBA9_8765_4321; in_cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", {63'd0, in_ready}, 64'd1);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_valid", {63'd0, out_valid}, 64'd0);
        check("abort_sum", out_sum, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid || busy) seen = 1'b1;
        end
        out_ready = 1'b0;
        check("abort_no_result", {63'd0, seen}, 64'd0);

        // Back-to-back with in_valid held high and the sink always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_a = b2b_a[i]; in_b = b2b_b[i]; in_cin = b2b_c[i]; in_sub = 1'b0; in_valid = 1'b1;
            bound = 0;
            while (!in_ready && bound < 20) begin
                @(posedge clk); #1;
                bound++;
            end
            acc_t[i] = cyc;
            @(posedge clk); #1;
            bound = 0;
            while (!out_valid && bound < 20) begin
                @(posedge clk); #1;
                bound++;
            end
            if (i == 2) in_valid = 1'b0;
            check($sformatf("b2b%0d_sum", i), out_sum, b2b_s[i]);
            check($sformatf("b2b%0d_cout", i), {63'd0, out_cout}, {63'd0, b2b_co[i]});
        end
        check("b2b_gap01", 64'(acc_t[1] - acc_t[0]), 64'd6);
        check("b2b_gap12", 64'(acc_t[2] - acc_t[1]), 64'd6);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("b2b_idle", {63'd0, in_ready}, 64'd1);

`ifdef ADDER_SEQ_SUB_EN
        run_op("sub_borrow", 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 0);
        run_op("sub_noborrow", 64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 0);
        run_op("sub_off", 64'd7, 64'd5, 1'b1, 1'b0, 64'd13, 1'b0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
